// File: rtl/pipe_pkg.sv
// pipe_pkg: clog2 helper and default reset data shared by pipeline register chains
package pipe_pkg;
    localparam int PIPE_RESET_DATA = 0;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/pipe_reg_chain_stage.sv
// pipe_stage: one elastic register stage (clk, reset async high, flush, src_valid/src_data in, next_ready in, ready/valid/data out)
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_DATA = WIDTH'(PIPE_RESET_DATA)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    input  logic             next_ready,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    assign ready = !valid | next_ready;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= RESET_DATA;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (ready) begin
            valid <= src_valid;
            if (src_valid) data <= src_data;
        end
    end
endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage elastic pipeline register (clk, reset async high, flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data, occupancy)
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter logic [WIDTH-1:0] RESET_DATA = WIDTH'(PIPE_RESET_DATA)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int OW = clog2(DEPTH + 1);
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic in_hs, out_hs;
    for (genvar i = 0; i < DEPTH; i++) begin : g
        logic r, nr, sv;
        logic [WIDTH-1:0] sd;
        if (i == 0) begin : g_src
            assign sv = in_hs;
            assign sd = in_data;
        end else begin : g_src
            assign sv = v[i-1];
            assign sd = d[i-1];
        end
        if (i == DEPTH - 1) begin : g_nr
            assign nr = out_ready;
        end else begin : g_nr
            assign nr = g[i+1].r;
        end
        pipe_stage #(.WIDTH(WIDTH), .RESET_DATA(RESET_DATA)) u_stage (
            .clk(clk), .reset(reset), .flush(flush),
            .src_valid(sv), .src_data(sd), .next_ready(nr),
            .ready(r), .valid(v[i]), .data(d[i])
        );
    end
    assign in_ready  = g[0].r & !flush;
    assign out_valid = v[DEPTH-1] & !flush;
    assign out_data  = d[DEPTH-1];
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) occupancy <= '0;
        else if (flush) occupancy <= '0;
        else if (in_hs != out_hs) occupancy <= in_hs ? occupancy + OW'(1) : occupancy - OW'(1);
    end
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: directed checks of pipe_reg_chain at DEPTH=3 and DEPTH=1
module tb_pipe_reg_chain;
    logic clk = 1'b0, reset = 1'b1;
    logic fl, iv, ordy, in_rdy, ov;
    logic [7:0] id, od;
    logic [1:0] occ;
    logic fl1, iv1, or1, ir1, ov1;
    logic [7:0] id1, od1;
    logic [0:0] occ1;
    int total = 0, bad = 0;
    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(8), .DEPTH(3)) u3 (
        .clk(clk), .reset(reset), .flush(fl), .in_valid(iv), .in_ready(in_rdy), .in_data(id),
        .out_valid(ov), .out_ready(ordy), .out_data(od), .occupancy(occ)
    );
    pipe_reg_chain #(.WIDTH(8), .DEPTH(1)) u1 (
        .clk(clk), .reset(reset), .flush(fl1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(occ1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] ex [5];
        int sent, recv;
        logic mv, ihs;
        fl = 0; iv = 0; id = 0; ordy = 0; fl1 = 0; iv1 = 0; id1 = 0; or1 = 0;
        tick; tick;
        reset = 0; #1;
        chk("rst_ov", ov, 0); chk("rst_occ", occ, 0); chk("rst_od", od, 0); chk("rst_ir", in_rdy, 1);
        ordy = 1; iv = 1; id = 8'h11; #1;
        chk("st_ir", in_rdy, 1);
        tick; id = 8'h22;
        tick; chk("st_lat", ov, 0); id = 8'h33;
        tick; iv = 0; #1;
        chk("st_ov1", ov, 1); chk("st_d11", od, 8'h11); chk("st_occ3", occ, 3);
        tick; chk("st_d22", od, 8'h22); chk("st_occ2", occ, 2);
        tick; chk("st_d33", od, 8'h33); chk("st_occ1", occ, 1);
        tick; chk("st_end_ov", ov, 0); chk("st_end_occ", occ, 0);
        ordy = 0; iv = 1; id = 8'hA1;
        tick; iv = 0; #1;
        chk("stl_ir1", in_rdy, 1); chk("stl_occ1", occ, 1);
        tick; iv = 1; id = 8'hA2; #1;
        chk("stl_ir_gap", in_rdy, 1);
        tick; id = 8'hA3; #1;
        chk("stl_ir2", in_rdy, 1); chk("stl_occ2", occ, 2);
        tick; id = 8'hA4; #1;
        chk("stl_ir_full", in_rdy, 0); chk("stl_occ3", occ, 3); chk("stl_ov", ov, 1); chk("stl_head", od, 8'hA1);
        tick; iv = 0; #1;
        chk("stl_hold_occ", occ, 3); chk("stl_hold_od", od, 8'hA1);
        ordy = 1;
        ex[0] = 8'hA1; ex[1] = 8'hA2; ex[2] = 8'hA3;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("drn_ov", ov, 1); chk("drn_od", od, ex[k]);
            tick;
        end
        chk("drn_empty", ov, 0); chk("drn_occ", occ, 0);
        ordy = 0; iv = 1;
        for (int k = 0; k < 3; k++) begin
            id = 8'hB0 + 8'(k);
            tick;
        end
        chk("full_occ", occ, 3); chk("full_ir", in_rdy, 0);
        ordy = 1;
        ex[0] = 8'hB0; ex[1] = 8'hB1; ex[2] = 8'hB2; ex[3] = 8'hC0; ex[4] = 8'hC1;
        for (int k = 0; k < 5; k++) begin
            id = 8'hC0 + 8'(k); #1;
            chk("sim_ir", in_rdy, 1); chk("sim_ov", ov, 1); chk("sim_od", od, ex[k]); chk("sim_occ", occ, 3);
            tick;
        end
        chk("sim_after_occ", occ, 3); chk("sim_after_od", od, 8'hC2);
        iv = 1; id = 8'hEE; fl = 1; #1;
        chk("fl_ir", in_rdy, 0); chk("fl_ov", ov, 0);
        tick; fl = 0; iv = 0; #1;
        chk("fl_occ", occ, 0); chk("fl_ov_after", ov, 0);
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("fl_no_accept", ov, 0);
        end
        chk("fl_data_hold", od, 8'hC2);
        ordy = 0; iv = 1; id = 8'hD1;
        tick; id = 8'hD2;
        tick; iv = 0; #1;
        chk("mr_occ2", occ, 2);
        reset = 1; #1;
        chk("mr_ov", ov, 0); chk("mr_occ", occ, 0); chk("mr_od", od, 0);
        tick; reset = 0; #1;
        chk("mr_ir", in_rdy, 1);
        sent = 0; recv = 0; mv = 0;
        for (int c = 0; c < 40 && recv < 8; c++) begin
            or1 = (c % 2 == 0); iv1 = (sent < 8); id1 = 8'(sent + 1); #1;
            chk("d1_ir", ir1, !mv | or1); chk("d1_occ", occ1, mv); chk("d1_ov", ov1, mv);
            if (mv && or1) begin
                chk("d1_data", od1, 32'(recv + 1));
                recv++;
            end
            ihs = iv1 && (!mv || or1);
            if (ihs) sent++;
            mv = ihs | (mv & !or1);
            tick;
        end
        chk("d1_recv", 32'(recv), 8); chk("d1_sent", 32'(sent), 8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
